// File: rtl/hades_pkt_verdict_stat_if.sv
// Byte-stream handshake into the header-inspection stage: valid/ready with sop/eop framing.
`timescale 1ns/1ps

interface hades_pkt_verdict_stat_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_sop;
    logic       s_eop;

    modport master (output s_valid, output s_data, output s_sop, output s_eop, input  s_ready);
    modport slave  (input  s_valid, input  s_data, input  s_sop, input  s_eop, output s_ready);
endinterface

// File: rtl/hades_pkt_verdict_stat.sv
// IPv4 header inspection: extracts protocol and destination port, issues one pass/drop
// verdict per packet and keeps a saturating drop counter readable through status_out.
`timescale 1ns/1ps

module hades_pkt_verdict_stat #(
    parameter int PROTO_OFFSET = 9,
    parameter int DPORT_OFFSET = 22
) (
    input  logic                           clk,
    input  logic                           reset_n,
    hades_pkt_verdict_stat_if.slave        in_if,
    input  logic                           filter_en,
    input  logic [7:0]                     block_proto,
    input  logic [15:0]                    block_port,
    input  logic                           cnt_clr,
    output logic                           verdict_valid,
    output logic                           verdict_drop,
    output logic [7:0]                     status_out
);

    localparam logic [7:0] PROTO_IDX    = 8'(PROTO_OFFSET);
    localparam logic [7:0] DPORT_HI_IDX = 8'(DPORT_OFFSET);
    localparam logic [7:0] DPORT_LO_IDX = 8'(DPORT_OFFSET + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        VERDICT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  byte_idx;
    logic [7:0]  proto_q;
    logic [7:0]  dport_hi_q;
    logic [7:0]  dport_lo_q;
    logic        seen;
    logic        last_drop;
    logic [5:0]  drop_cnt;

    logic        beat;
    logic        restart;
    logic        cap_en;
    logic        verdict_now;
    logic        eop_short;
    logic [15:0] dport_eff;
    logic        drop_now;

    // Gated by reset_n so the stream is refused (and all outputs read 0) while held in reset.
    assign in_if.s_ready = reset_n && (state_q != VERDICT);
    assign beat          = in_if.s_valid && in_if.s_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: registers update with <= so every flop samples pre-edge values together.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default here first, otherwise missed branches infer latches.
        state_d     = state_q;
        restart     = 1'b0;
        cap_en      = 1'b0;
        verdict_now = 1'b0;
        eop_short   = 1'b0;
        case (state_q)
            IDLE: begin
                if (beat && in_if.s_sop) begin
                    restart = 1'b1;
                    if (in_if.s_eop) begin
                        verdict_now = 1'b1;
                        eop_short   = 1'b1;
                        state_d     = VERDICT;
                    end else begin
                        state_d = HDR;
                    end
                end
            end
            HDR: begin
                if (beat) begin
                    // A fresh sop abandons the current packet silently and starts over.
                    if (in_if.s_sop) begin
                        restart = 1'b1;
                        if (in_if.s_eop) begin
                            verdict_now = 1'b1;
                            eop_short   = 1'b1;
                            state_d     = VERDICT;
                        end
                    end else begin
                        cap_en = 1'b1;
                        if (in_if.s_eop) begin
                            verdict_now = 1'b1;
                            eop_short   = (byte_idx < DPORT_LO_IDX);
                            state_d     = VERDICT;
                        end
                    end
                end
            end
            VERDICT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The port LSB may arrive on the eop beat itself, so bypass the capture register then.
    assign dport_eff = {dport_hi_q, (byte_idx == DPORT_LO_IDX) ? in_if.s_data : dport_lo_q};
    assign drop_now  = eop_short ||
                       (filter_en && (proto_q == block_proto) && (dport_eff == block_port));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx      <= 8'd0;
            proto_q       <= 8'd0;
            dport_hi_q    <= 8'd0;
            dport_lo_q    <= 8'd0;
            verdict_valid <= 1'b0;
            verdict_drop  <= 1'b0;
            seen          <= 1'b0;
            last_drop     <= 1'b0;
            drop_cnt      <= 6'd0;
        end else begin
            if (restart) begin
                byte_idx <= 8'd1;
            end else if (cap_en && (byte_idx != 8'hFF)) begin
                byte_idx <= byte_idx + 8'd1;
            end

            if (cap_en) begin
                if (byte_idx == PROTO_IDX)    proto_q    <= in_if.s_data;
                if (byte_idx == DPORT_HI_IDX) dport_hi_q <= in_if.s_data;
                if (byte_idx == DPORT_LO_IDX) dport_lo_q <= in_if.s_data;
            end

            verdict_valid <= verdict_now;
            verdict_drop  <= verdict_now && drop_now;

            if (verdict_now) begin
                seen      <= 1'b1;
                last_drop <= drop_now;
            end

            // Clear wins over the old count, but a coincident drop still counts once.
            if (cnt_clr) begin
                drop_cnt <= (verdict_now && drop_now) ? 6'd1 : 6'd0;
            end else if (verdict_now && drop_now && (drop_cnt != 6'd63)) begin
                drop_cnt <= drop_cnt + 6'd1;
            end
        end
    end

    assign status_out = {seen, last_drop, drop_cnt};

endmodule
